usb_bitstuff_stream: RTL
========================

Name: usb_bitstuff_stream

Overview:
- Parametrised successor to the USB SIE transmit bit stuffer.
- Takes a serial bit stream with valid/ready handshake and packet framing; after RUN_LEN consecutive MARK_BIT bits it inserts one complemented bit, stalling the source for that bit period.
- Adds a bypass for unstuffed fields (SYNC/EOP), end-of-packet stuff flush, optional NRZI encoding and a saturating stuff counter.
- Sits between the TX serialiser and the line driver.

Parameters:
RUN_LEN, 6, run length that triggers a stuff bit; legal 2..15
MARK_BIT, 1, bit value whose run is counted; the stuffed bit is ~MARK_BIT
NRZI_EN, 1, 1 = out_nrzi carries NRZI-encoded stream; 0 = out_nrzi mirrors out_data
STAT_W, 16, width of stuff_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
bit_en  in  1  bit-period strobe; all stream state advances only on cycles with bit_en=1
in_valid  in  1  source has a bit
in_data  in  1  source bit
in_last  in  1  source bit is the final bit of the packet
in_bypass  in  1  bit is neither counted nor stuffed (SYNC/EOP fields)
in_ready  out  1  combinational: bit_en & ~stuff_pend
out_valid  out  1  one-cycle pulse: out_data/out_nrzi updated this cycle
out_data  out  1  stuffed NRZ bit
out_nrzi  out  1  NRZI line level
out_stuff  out  1  current output bit is an inserted stuff bit
out_last  out  1  current output bit ends the packet
clr_stats  in  1  synchronous clear of stuff_cnt
stuff_cnt  out  STAT_W  saturating count of inserted stuff bits

Behaviour:
- Reset (async, rst=0): run=0, stuff_pend=0, last_pend=0, out_valid=0, out_data=MARK_BIT, out_nrzi=1 (J), out_stuff=0, out_last=0, stuff_cnt=0.
- Transfer occurs when in_valid & in_ready. Latency is 1 clk: transferred or stuffed bit appears on registered outputs the next cycle with out_valid=1. Outputs hold between bit periods.
- Bit-period priority on a bit_en cycle:
  1) stuff_pend=1: emit ~MARK_BIT, out_stuff=1, out_last=last_pend, run=0, stuff_pend=0, stuff_cnt+1 (saturates at all-ones). in_ready=0, so no transfer occurs. Stuff takes priority over bypass and new data.
  2) transfer, in_bypass=1: emit in_data, out_stuff=0, out_last=in_last, run=0.
  3) transfer, in_bypass=0, in_data==MARK_BIT:
     - run+1 == RUN_LEN: stuff_pend=1, last_pend=in_last, out_last=0. The packet end moves onto the stuff bit.
     - otherwise: run=run+1, out_last=in_last.
  4) transfer, in_data!=MARK_BIT: run=0, out_last=in_last.
  5) no transfer (in_valid=0): out_valid stays 0 next cycle, run held; an underrun gap does not break a run.
- After any emitted bit with out_last=1, run=0 so packets are independent.
- Run counter width: clog2(RUN_LEN+1) bits; never exceeds RUN_LEN-1 while stuff_pend=0.
- NRZI (NRZI_EN=1): on every emitted bit, including stuff bits, out_nrzi toggles if the bit is 0 and holds if it is 1. With NRZI_EN=0, out_nrzi = out_data.
- bit_en=0 cycles: no state change, in_ready=0, out_valid=0.
- clr_stats: stuff_cnt=0 next cycle. If it coincides with a stuff emission, the result is 1.
- Reset mid-packet: all state is discarded immediately. The next packet starts with run=0 and no pending stuff.

Test Plan:
- MARK_BIT=1, RUN_LEN=6, bit_en always 1, stream 1111111 0 -> out_data 1111110 1 0; out_stuff pulses only on the 7th output; in_ready low exactly 1 cycle; stuff_cnt=1.
- Six 1s with in_last on the 6th -> 6 ones, then stuff 0 with out_last=1; out_last=0 on the 6th one; next packet's first 1 gives run=1.
- in_bypass=1 for SYNC 00000001 followed by 1111 0 data -> no stuff in SYNC; the SYNC's trailing 1 does not count toward the data run.
- NRZI_EN=1, from reset, emit 0,1,0 then stuff 0 -> out_nrzi 0,0,1,0 (toggle, hold, toggle, toggle).
- bit_en every 4th clk, in_valid dropped for 2 bit periods between the 3rd and 4th 1 of a run -> stuff still after the 6th 1; out_valid pulses only in bit periods with output.
- STAT_W=2, 5 stuff events -> stuff_cnt 1,2,3,3,3. clr_stats on the same cycle as a stuff emission -> 1. rst pulsed mid-run (run=4) -> the next five 1s produce no stuff.

Source files
------------

// File: rtl/usb_bitstuff_stream.sv
// USB transmit bit stuffer: inserts ~MARK_BIT after RUN_LEN consecutive MARK_BIT bits,
// with bypass for unstuffed fields, end-of-packet flush onto the stuff bit, NRZI and stats.
module usb_bitstuff_stream #(
  parameter int   RUN_LEN  = 6,
  parameter logic MARK_BIT = 1'b1,
  parameter bit   NRZI_EN  = 1'b1,
  parameter int   STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              in_valid,
  input  logic              in_data,
  input  logic              in_last,
  input  logic              in_bypass,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_data,
  output logic              out_nrzi,
  output logic              out_stuff,
  output logic              out_last,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] stuff_cnt
);

  // state    | meaning
  // ST_PASS  | source bits flow through, run counter tracks MARK_BIT runs
  // ST_STUFF | run complete; next bit period emits ~MARK_BIT and stalls the source
  typedef enum logic {ST_PASS, ST_STUFF} state_t;

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_LEN - 1);
  localparam logic [STAT_W-1:0] CNT_MAX = {STAT_W{1'b1}};

  if (RUN_LEN < 2 || RUN_LEN > 15) begin : g_bad_run_len
    $error("usb_bitstuff_stream: RUN_LEN must be in 2..15");
  end

  state_t           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt;
  logic             r_last_pend, w_last_pend_nxt;
  logic             r_out_valid, w_valid_nxt;
  logic             r_out_data, w_data_nxt;
  logic             r_out_stuff, w_stuff_nxt;
  logic             r_out_last, w_last_nxt;
  logic             r_nrzi, w_nrzi_nxt;
  logic [STAT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_stuff_emit;

  assign in_ready  = bit_en & (r_state == ST_PASS);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_stuff = r_out_stuff;
  assign out_last  = r_out_last;
  assign out_nrzi  = NRZI_EN ? r_nrzi : r_out_data;
  assign stuff_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_PASS;
      r_run       <= '0;
      r_last_pend <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= MARK_BIT;
      r_out_stuff <= 1'b0;
      r_out_last  <= 1'b0;
      r_nrzi      <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_last_pend <= w_last_pend_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
      r_out_stuff <= w_stuff_nxt;
      r_out_last  <= w_last_nxt;
      r_nrzi      <= w_nrzi_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_run_nxt       = r_run;
    w_last_pend_nxt = r_last_pend;
    w_valid_nxt     = 1'b0;
    w_data_nxt      = r_out_data;
    w_stuff_nxt     = r_out_stuff;
    w_last_nxt      = r_out_last;
    w_stuff_emit    = 1'b0;
    if (bit_en) begin
      if (r_state == ST_STUFF) begin
        w_stuff_emit    = 1'b1;
        w_valid_nxt     = 1'b1;
        w_data_nxt      = ~MARK_BIT;
        w_stuff_nxt     = 1'b1;
        w_last_nxt      = r_last_pend;
        w_run_nxt       = '0;
        w_last_pend_nxt = 1'b0;
        w_state_nxt     = ST_PASS;
      end else if (in_valid) begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = in_data;
        w_stuff_nxt = 1'b0;
        w_last_nxt  = in_last;
        if (in_bypass || (in_data != MARK_BIT)) begin
          w_run_nxt = '0;
        end else if (r_run == RUN_TOP) begin
          // packet end is deferred onto the stuff bit that follows
          w_state_nxt     = ST_STUFF;
          w_last_pend_nxt = in_last;
          w_last_nxt      = 1'b0;
          w_run_nxt       = '0;
        end else begin
          w_run_nxt = r_run + RUN_W'(1);
        end
        if (w_last_nxt) w_run_nxt = '0;
      end
    end
  end

  always_comb begin
    w_nrzi_nxt = r_nrzi;
    if (w_valid_nxt && !w_data_nxt) w_nrzi_nxt = ~r_nrzi;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_stats) begin
      w_cnt_nxt = w_stuff_emit ? STAT_W'(1) : '0;
    end else if (w_stuff_emit && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + STAT_W'(1);
    end
  end

endmodule
